// File: rtl/iiitb_pusr.sv
// Parametrised universal shift register with single-step modes and multi-step bursts.
// Define USR_PARITY_EN to add the parity_out port (XOR of data_out).
module iiitb_pusr #(
    parameter int WIDTH = 8,
    localparam int SHW  = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             sl_ser,
    input  logic             sr_ser,
    input  logic             start,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] data_out,
    output logic             sl_out,
    output logic             sr_out,
    output logic             busy,
`ifdef USR_PARITY_EN
    output logic             done,
    output logic             parity_out
`else
    output logic             done
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [SHW-1:0] MAX_STEPS = SHW'(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [SHW-1:0]   r_count;
    logic [2:0]       r_mode;
    logic             r_done;

    state_t           w_nextState;
    logic [WIDTH-1:0] w_nextQ;
    logic [SHW-1:0]   w_nextCount;
    logic [2:0]       w_nextMode;
    logic             w_nextDone;
    logic [2:0]       w_stepMode;
    logic [WIDTH-1:0] w_stepResult;
    logic             w_isShift;
    logic [SHW-1:0]   w_steps;

    // In RUN the latched mode drives the datapath; live inputs are ignored.
    assign w_stepMode = (r_state == RUN) ? r_mode : mode;
    assign w_isShift  = (mode == 3'b001) || (mode == 3'b010) || (mode == 3'b100) ||
                        (mode == 3'b101) || (mode == 3'b110);
    assign w_steps    = (shamt > MAX_STEPS) ? MAX_STEPS : shamt;

    always_comb begin
        w_stepResult = r_q;
        case (w_stepMode)
            3'b000:  w_stepResult = r_q;
            3'b001:  w_stepResult = {r_q[WIDTH-2:0], sl_ser};
            3'b010:  w_stepResult = {sr_ser, r_q[WIDTH-1:1]};
            3'b011:  w_stepResult = data_in;
            3'b100:  w_stepResult = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            3'b101:  w_stepResult = {r_q[0], r_q[WIDTH-1:1]};
            3'b110:  w_stepResult = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
            default: w_stepResult = '0;
        endcase
    end

    always_comb begin
        w_nextState = r_state;
        w_nextQ     = r_q;
        w_nextCount = r_count;
        w_nextMode  = r_mode;
        w_nextDone  = 1'b0;
        if (en) begin
            w_nextQ = w_stepResult;
            case (r_state)
                IDLE: begin
                    if (start && w_isShift && (shamt != '0)) begin
                        w_nextMode = mode;
                        if (w_steps == SHW'(1)) begin
                            w_nextDone = 1'b1;
                        end else begin
                            w_nextCount = w_steps - SHW'(1);
                            w_nextState = RUN;
                        end
                    end
                end
                RUN: begin
                    w_nextCount = r_count - SHW'(1);
                    if (r_count == SHW'(1)) begin
                        w_nextState = IDLE;
                        w_nextDone  = 1'b1;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Reset wins over everything, so a mid-burst clear aborts without a done pulse.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_count <= '0;
            r_mode  <= 3'b000;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_q     <= w_nextQ;
            r_count <= w_nextCount;
            r_mode  <= w_nextMode;
            r_done  <= w_nextDone;
        end
    end

    assign data_out = r_q;
    assign sl_out   = r_q[WIDTH-1];
    assign sr_out   = r_q[0];
    assign busy     = (r_state == RUN);
    assign done     = r_done;
`ifdef USR_PARITY_EN
    assign parity_out = ^r_q;
`endif

endmodule

// File: tb/tb_iiitb_pusr.sv
// Directed self-checking bench for iiitb_pusr (WIDTH=8); expected values are hand-computed.
// Checks parity_out as well when USR_PARITY_EN is defined.
module tb_iiitb_pusr;

    logic       clock;
    logic       clear_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] data_in;
    logic       sl_ser;
    logic       sr_ser;
    logic       start;
    logic [3:0] shamt;
    logic [7:0] data_out;
    logic       sl_out;
    logic       sr_out;
    logic       busy;
    logic       done;
`ifdef USR_PARITY_EN
    logic       parity_out;
`endif

    int nChecks = 0;
    int nErrors = 0;

    iiitb_pusr #(.WIDTH(8)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .en       (en),
        .mode     (mode),
        .data_in  (data_in),
        .sl_ser   (sl_ser),
        .sr_ser   (sr_ser),
        .start    (start),
        .shamt    (shamt),
        .data_out (data_out),
        .sl_out   (sl_out),
        .sr_out   (sr_out),
        .busy     (busy),
`ifdef USR_PARITY_EN
        .done       (done),
        .parity_out (parity_out)
`else
        .done     (done)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input logic [7:0] expQ,
                              input logic expBusy, input logic expDone);
        checkOutput({tag, ".data"}, 32'(data_out), 32'(expQ));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
        checkOutput({tag, ".done"}, 32'(done), 32'(expDone));
`ifdef USR_PARITY_EN
        checkOutput({tag, ".parity"}, 32'(parity_out), 32'(^expQ));
`endif
    endtask

    // Drives inputs away from the edge, then samples 1ns after the next rising edge.
    task automatic applyStimulus(input logic e, input logic [2:0] m, input logic [7:0] d,
                                 input logic sl, input logic sr, input logic st,
                                 input logic [3:0] sh);
        en      = e;
        mode    = m;
        data_in = d;
        sl_ser  = sl;
        sr_ser  = sr;
        start   = st;
        shamt   = sh;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] expQ;
        clear_n = 1'b1;
        en = 1'b0; mode = 3'b000; data_in = 8'h00;
        sl_ser = 1'b0; sr_ser = 1'b0; start = 1'b0; shamt = 4'd0;
        #2;

        // Reset with a nonzero register, reset overrides an enabled load
        applyStimulus(1, 3'b011, 8'hA5, 0, 0, 0, 0);
        checkState("preload", 8'hA5, 0, 0);
        clear_n = 1'b0;
        applyStimulus(1, 3'b011, 8'h5A, 0, 0, 0, 0);
        checkState("reset", 8'h00, 0, 0);
        clear_n = 1'b1;
        applyStimulus(0, 3'b011, 8'hFF, 0, 0, 1, 4'd3);
        checkState("holdEn0", 8'h00, 0, 0);

        // Load then shift left
        applyStimulus(1, 3'b011, 8'hB4, 0, 0, 0, 0);
        checkState("load", 8'hB4, 0, 0);
        applyStimulus(1, 3'b001, 8'h00, 1, 0, 0, 0);
        checkState("shl", 8'h69, 0, 0);
        checkOutput("shl.sl_out", 32'(sl_out), 32'd0);
        checkOutput("shl.sr_out", 32'(sr_out), 32'd1);

        // Single steps: rotr, hold, zero
        applyStimulus(1, 3'b011, 8'h81, 0, 0, 0, 0);
        applyStimulus(1, 3'b101, 8'h00, 0, 0, 0, 0);
        checkState("rotr", 8'hC0, 0, 0);
        applyStimulus(1, 3'b000, 8'hFF, 1, 1, 0, 0);
        checkState("hold", 8'hC0, 0, 0);
        applyStimulus(1, 3'b111, 8'hFF, 1, 1, 0, 0);
        checkState("zero", 8'h00, 0, 0);

        // Start with shamt=0 or a non-shift mode is a plain single step
        applyStimulus(1, 3'b011, 8'h01, 0, 0, 1, 4'd5);
        checkState("startLoad", 8'h01, 0, 0);
        applyStimulus(1, 3'b100, 8'h00, 0, 0, 1, 4'd0);
        checkState("startZero", 8'h02, 0, 0);
        applyStimulus(1, 3'b001, 8'h00, 1, 0, 1, 4'd1);
        checkState("burst1", 8'h05, 0, 1);
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        checkState("burst1.after", 8'h05, 0, 0);

        // Rotate-left burst of 3
        applyStimulus(1, 3'b011, 8'h81, 0, 0, 0, 0);
        applyStimulus(1, 3'b100, 8'h00, 0, 0, 1, 4'd3);
        checkState("rotl.s1", 8'h03, 1, 0);
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        checkState("rotl.s2", 8'h06, 1, 0);
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        checkState("rotl.s3", 8'h0C, 0, 1);
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        checkState("rotl.after", 8'h0C, 0, 0);

        // Arithmetic-right burst with a 3-cycle pause
        applyStimulus(1, 3'b011, 8'h90, 0, 0, 0, 0);
        applyStimulus(1, 3'b110, 8'h00, 0, 0, 1, 4'd2);
        checkState("ashr.s1", 8'hC8, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 3'b111, 8'h00, 0, 0, 1, 4'd5);
            checkState("ashr.pause", 8'hC8, 1, 0);
        end
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        checkState("ashr.s2", 8'hE4, 0, 1);

        // Clamped burst (12 -> 8); start/mode/shamt changes during RUN are ignored
        applyStimulus(1, 3'b011, 8'hFF, 0, 0, 0, 0);
        applyStimulus(1, 3'b001, 8'h00, 0, 0, 1, 4'd12);
        checkState("clamp.s1", 8'hFE, 1, 0);
        for (int k = 2; k <= 8; k++) begin
            applyStimulus(1, 3'b010, 8'h00, 0, 1, 1, 4'd2);
            expQ = 8'hFF << k;
            checkState($sformatf("clamp.s%0d", k), expQ, (k < 8), (k == 8));
        end
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        checkState("clamp.after", 8'h00, 0, 0);

        // Same burst aborted by reset at step 4
        applyStimulus(1, 3'b011, 8'hFF, 0, 0, 0, 0);
        applyStimulus(1, 3'b001, 8'h00, 0, 0, 1, 4'd12);
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        checkState("abort.s3", 8'hF8, 1, 0);
        clear_n = 1'b0;
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        checkState("abort.reset", 8'h00, 0, 0);
        clear_n = 1'b1;
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        checkState("abort.after", 8'h00, 0, 0);

        // Serial input sampled live on each burst step
        applyStimulus(1, 3'b010, 8'h00, 0, 1, 1, 4'd2);
        checkState("serial.s1", 8'h80, 1, 0);
        applyStimulus(1, 3'b000, 8'h00, 0, 0, 0, 0);
        checkState("serial.s2", 8'h40, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
